// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encodings and parity-mode constants.
package sipo_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/shift_reg_sipo_en.sv
// WIDTH-bit serial-in parallel-out shift register; first bit shifted in ends up in the MSB.
module shift_reg_sipo_en
    import sipo_frame_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= {q_q[WIDTH-2:0], din};
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Serial frame receiver: start bit, WIDTH data bits (MSB first), optional parity, stop bit,
// delivered as a registered parallel word with a valid/ready handshake.
module sipo_frame_ctrl
    import sipo_frame_ctrl_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 1,
    parameter int ODD       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sdi,
    input  logic             bit_en,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             busy,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
    localparam logic           ODD_BIT  = (ODD != 0) ? PAR_ODD : PAR_EVEN;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             par_bad_q, par_bad_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             pe_q, pe_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;
    logic             sh_clr, sh_en, done;
    logic [WIDTH-1:0] shift_w;

    shift_reg_sipo_en #(.WIDTH(WIDTH)) u_shift (
        .clk (clk),
        .rst (reset),
        .clr (sh_clr),
        .en  (sh_en),
        .din (sdi),
        .q   (shift_w)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        par_bad_d = par_bad_q;
        data_d    = data_q;
        valid_d   = valid_q;
        pe_d      = 1'b0;
        fe_d      = 1'b0;
        ov_d      = 1'b0;
        sh_clr    = 1'b0;
        sh_en     = 1'b0;
        done      = 1'b0;

        if (bit_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!sdi) begin
                        sh_clr    = 1'b1;
                        cnt_d     = '0;
                        par_d     = 1'b0;
                        par_bad_d = 1'b0;
                        state_d   = ST_DATA;
                    end
                end
                ST_DATA: begin
                    sh_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    par_d = par_q ^ sdi;
                    if (cnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    par_bad_d = ((par_q ^ sdi) != ODD_BIT);
                    state_d   = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    // A bad stop bit masks any parity problem in the same frame.
                    if (!sdi) begin
                        fe_d = 1'b1;
                    end else if (par_bad_q) begin
                        pe_d = 1'b1;
                    end else begin
                        done = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (done) begin
            if (!valid_q || ready) begin
                data_d  = shift_w;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            par_bad_q <= par_bad_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign overrun    = ov_q;

endmodule
